// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts a WIDTH-bit word over valid/ready
// and emits it LSB-first after one guaranteed downstream-clear cycle.
module serial_word_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_bit,
    output logic             ser_clr,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PENULT  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // ser_bit/ser_last are registered one edge ahead of the counter, so the bit
    // for SHIFT cycle n is loaded on the edge entering that cycle.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            ser_bit  <= 1'b0;
            ser_clr  <= 1'b1;
            ser_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ser_bit  <= 1'b0;
                    ser_clr  <= 1'b1;
                    ser_last <= 1'b0;
                    if (load_valid) begin
                        state <= CLR;
                        sreg  <= load_data;
                        cnt   <= '0;
                    end
                end
                CLR: begin
                    state    <= SHIFT;
                    ser_bit  <= sreg[0];
                    sreg     <= sreg >> 1;
                    ser_clr  <= 1'b0;
                    ser_last <= 1'b0;
                    cnt      <= '0;
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        ser_bit  <= 1'b0;
                        ser_clr  <= 1'b1;
                        ser_last <= 1'b0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ser_bit  <= sreg[0];
                        sreg     <= sreg >> 1;
                        ser_clr  <= 1'b0;
                        ser_last <= (cnt == CNT_PENULT);
                    end
                end
                default: begin
                    state    <= IDLE;
                    ser_bit  <= 1'b0;
                    ser_clr  <= 1'b1;
                    ser_last <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: per-cycle comparison against a
// cycle-offset model, plus directed literal checks on the serial streams.
module tb_serial_word_tx;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready, ser_bit, ser_clr, ser_last, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: d = cycles since the accepting edge (-1 when no word in flight).
    int           d = -1;
    logic [W-1:0] w = '0;

    logic         bits_q[$];
    int           last_q[$];

    serial_word_tx #(.WIDTH(W)) dut (
        .t_clk      (t_clk),
        .r          (r),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_bit    (ser_bit),
        .ser_clr    (ser_clr),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 t_clk = ~t_clk;

    always @(posedge t_clk) cyc <= cyc + 1;

    always @(posedge t_clk or posedge r) begin
        if (r) begin
            d = -1;
        end else if (d < 0) begin
            if (load_valid) begin
                w = load_data;
                d = 1;
            end
        end else if (d == W + 1) begin
            d = -1;
        end else begin
            d = d + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle against the model, and stream capture.
    always @(negedge t_clk) begin
        logic e_bit;
        e_bit = (d >= 2) ? w[d-2] : 1'b0;
        chk("load_ready", load_ready, d < 0);
        chk("busy",       busy,       d >= 0);
        chk("ser_clr",    ser_clr,    d < 2);
        chk("ser_bit",    ser_bit,    e_bit);
        chk("ser_last",   ser_last,   d == W + 1);
        if (!ser_clr && !r) bits_q.push_back(ser_bit);
        if (ser_last) last_q.push_back(cyc);
    end

    function automatic logic [W-1:0] pack_bits(input int base);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i] = bits_q[base + i];
        return v;
    endfunction

    function automatic logic [W-1:0] complement_stream(input int base);
        logic [W-1:0] v;
        logic seen;
        v = '0;
        seen = 1'b0;
        for (int i = 0; i < W; i++) begin
            v[i] = bits_q[base + i] ^ seen;
            seen = seen | bits_q[base + i];
        end
        return v;
    endfunction

    task automatic clear_log();
        bits_q.delete();
        last_q.delete();
    endtask

    // Present a word for one edge; returns the cycle number of the accepting edge.
    task automatic pulse_word(input logic [W-1:0] data, output int acc);
        @(posedge t_clk); #2;
        load_valid = 1'b1;
        load_data  = data;
        @(posedge t_clk); #1;
        acc = cyc;
        #1;
        load_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int acc2;
        repeat (2) @(posedge t_clk);
        #2 r = 1'b0;

        // Reset then idle
        repeat (10) @(posedge t_clk);
        #1;
        chk("idle_ready", load_ready, 1);
        chk("idle_clr", ser_clr, 1);

        // Single word 8'h68
        clear_log();
        pulse_word(8'h68, acc);
        repeat (12) @(posedge t_clk);
        #1;
        chk("h68_nbits", bits_q.size(), 8);
        if (bits_q.size() == 8) begin
            chk("h68_word", pack_bits(0), 8'h68);
            chk("h68_complement", complement_stream(0), 8'h98);
        end
        chk("h68_nlast", last_q.size(), 1);
        if (last_q.size() == 1) chk("h68_last_latency", last_q[0] - acc, 8);

        // Back-to-back FF then 01
        clear_log();
        @(posedge t_clk); #2;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(posedge t_clk); #1;
        acc = cyc;
        #1 load_data = 8'h01;
        repeat (10) @(posedge t_clk);
        #1 acc2 = cyc;
        #1 load_valid = 1'b0;
        repeat (12) @(posedge t_clk);
        #1;
        chk("b2b_period", acc2 - acc, 10);
        chk("b2b_nbits", bits_q.size(), 16);
        if (bits_q.size() == 16) begin
            chk("b2b_word0", pack_bits(0), 8'hFF);
            chk("b2b_word1", pack_bits(8), 8'h01);
        end
        chk("b2b_nlast", last_q.size(), 2);
        if (last_q.size() == 2) chk("b2b_last_gap", last_q[1] - last_q[0], 10);

        // Load ignored while busy
        clear_log();
        pulse_word(8'hA5, acc);
        repeat (3) @(posedge t_clk);
        #2;
        load_valid = 1'b1;
        load_data  = 8'h00;
        @(posedge t_clk); #2;
        load_valid = 1'b0;
        repeat (14) @(posedge t_clk);
        #1;
        chk("busy_nbits", bits_q.size(), 8);
        if (bits_q.size() == 8) chk("busy_word", pack_bits(0), 8'hA5);
        chk("busy_nlast", last_q.size(), 1);

        // Asynchronous reset mid-word, during SHIFT cycle 3
        clear_log();
        pulse_word(8'hFF, acc);
        repeat (3) @(posedge t_clk);
        #1;
        chk("pre_rst_bit", ser_bit, 1);
        #2 r = 1'b1;
        #1;
        chk("async_rst_bit", ser_bit, 0);
        chk("async_rst_clr", ser_clr, 1);
        chk("async_rst_busy", busy, 0);
        @(posedge t_clk); #2;
        r = 1'b0;
        clear_log();
        #1;
        chk("post_rst_ready", load_ready, 1);
        repeat (12) @(posedge t_clk);
        #1;
        chk("post_rst_nbits", bits_q.size(), 0);

        // Randomised traffic with data churn while busy
        for (int i = 0; i < 400; i++) begin
            @(posedge t_clk); #2;
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = W'($urandom);
        end
        @(posedge t_clk); #2;
        load_valid = 1'b0;
        repeat (12) @(posedge t_clk);
        @(negedge t_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
